mantissa_align_pipe: RTL and testbench
======================================

// Module: mantissa_align_pipe
// PURPOSE
//  Pipelined, elastic successor to the combinational alignment stage of the FP add/sub datapath.
//  Right-shifts the smaller operand's significand {hidden,mantissa} by |exponent difference|.
//  Produces guard/round/sticky bits for IEEE rounding. Saturates large shifts into sticky.
//  Sits between exponent compare (stage1) and mantissa addition (stage3), using valid/ready handshakes.
// PARAMETERS
//  MENT_WIDTH  23  stored mantissa width (hidden bit excluded)
//  EXPO_WIDTH  8   exponent width; shift input is EXPO_WIDTH+1 bits, two's complement
//  PIPE_STAGES 2   register stages across the shifter, range 1..3; equals latency in cycles
//  SIDE_WIDTH  10  sideband bits passed through in lockstep (sign, larger exponent, op)
// PORTS
//  clk               in   1               clock, rising edge
//  rst               in   1               synchronous reset, active-high
//  in_valid          in   1               input beat valid
//  in_ready          out  1               block accepts a beat this cycle
//  hidden_in         in   1               hidden bit (0 for denormal operand)
//  smaller_operand_in in  MENT_WIDTH      mantissa of the smaller operand
//  rshift_in         in   EXPO_WIDTH+1    signed exponent difference
//  side_in           in   SIDE_WIDTH      sideband, unmodified
//  out_valid         out  1               output beat valid
//  out_ready         in   1               downstream accepts
//  aligned_out       out  MENT_WIDTH+4    {shifted significand[MENT_WIDTH:0], G, R, S}
//  shift_sat_out     out  1               shift magnitude >= MENT_WIDTH+3
//  side_out          out  SIDE_WIDTH      sideband aligned with aligned_out
// BEHAVIOUR
//  - Shift magnitude: sh = rshift_in[EXPO_WIDTH] ? -rshift_in : rshift_in.
//    Computed at EXPO_WIDTH+1 bits, so -2^EXPO_WIDTH gives 2^EXPO_WIDTH.
//  - ext = {hidden_in, smaller_operand_in, 2'b00}, which is MENT_WIDTH+3 bits.
//  - If sh < MENT_WIDTH+3: aligned_out = {ext>>sh, S}, where S = OR of the bits shifted out.
//  - If sh >= MENT_WIDTH+3: upper bits are 0, S = |ext, and shift_sat_out = 1.
//  - Pipeline advance: en = !out_valid || out_ready; in_ready = en (combinational, global stall).
//  - A beat is accepted on in_valid && in_ready.
//  - When en = 1, every stage's valid bit takes the previous stage's valid bit.
//  - Bubbles travel through the pipe; the block does not compress them.
//  - When en = 0, all stage registers hold.
//  - Latency: exactly PIPE_STAGES cycles from acceptance to out_valid, with out_ready held high.
//  - Throughput: 1 beat per cycle. Order is preserved; no beat is lost or duplicated.
//  - Shifter levels (log2 of the shift range) are split evenly across stages; earlier stages take any extra level.
//  - Sticky is accumulated per level and carried in the stage registers.
//  - Reset: all valid bits, aligned_out, shift_sat_out and side_out clear to 0 on the next edge.
//  - Reset mid-operation flushes all in-flight beats. out_valid stays 0 until a new beat has traversed the pipe.
//  - in_valid is ignored during rst.
//  - Holding rules: while out_valid && !out_ready, the outputs hold stable. An upstream change with in_ready = 0 has no effect.
// CONFIGURATION
//  - ALIGN_STICKY_EN defined: S is computed as above.
//  - ALIGN_STICKY_EN undefined: S is forced to 0 and the sticky logic is removed (truncation mode).
//    G, R and shift_sat_out are unchanged in this mode.
// STRUCTURE
//  - Package fpu_align_pkg holds:
//    - ALIGN_WIDTH = MENT_WIDTH+4 and SHIFT_SAT = MENT_WIDTH+3
//    - function shift_mag(), giving the two's-complement magnitude
//    - typedef of the stage payload struct {sig, sticky, sat, sh_rem, side}
//  - Sub-module align_shift_stage applies a contiguous group of shift levels and ORs the dropped bits into sticky.
//    It is instantiated once per pipeline stage.
// TESTING
//  Defaults apply and ALIGN_STICKY_EN is defined unless stated.
//  1. hidden=1, mant=0, rshift=+1 -> aligned_out=27'h2000000, sat=0, after 2 cycles.
//  2. hidden=1, mant=0, rshift=9'h1FF (-1) -> aligned_out=27'h2000000. rshift=0 -> 27'h4000000.
//  3. hidden=1, mant=23'h000001, rshift=25 -> aligned_out=27'h0000003.
//     Same operands with rshift=26 -> 27'h0000001, sat=1.
//     Same operands with rshift=9'h100 -> 27'h0000001, sat=1.
//  4. Three back-to-back beats with out_ready low for 4 cycles:
//     - in_ready goes low once out_valid is high.
//     - All 3 beats emerge in order with matching side_out, with no duplicates.
//  5. rst for 1 cycle while 2 beats are in flight -> out_valid=0 and aligned_out=0 the next cycle.
//     No stale beat emerges afterwards.
//  6. ALIGN_STICKY_EN undefined, stimulus of case 3 (rshift=26) -> aligned_out=0, sat=1.
//     rshift=25 -> aligned_out=27'h0000002.

Source files
------------

// File: rtl/mantissa_align_pipe_pkg.sv
// Shared widths, payload type and helpers for the mantissa alignment pipe.
// Datapath widths live here; the pipe itself only exposes PIPE_STAGES.
package fpu_align_pkg;

   localparam int MENT_WIDTH  = 23;
   localparam int EXPO_WIDTH  = 8;
   localparam int SIDE_WIDTH  = 10;
   localparam int ALIGN_WIDTH = MENT_WIDTH + 4;
   localparam int SHIFT_SAT   = MENT_WIDTH + 3;
   // Shift bits that still matter once saturation has been peeled off.
   localparam int SH_BITS     = $clog2(SHIFT_SAT);

   // Payload carried between shifter stages.
   typedef struct packed {
      logic [SHIFT_SAT-1:0]  sig;     // {hidden, mantissa, G, R}
      logic                  sticky;  // OR of every bit dropped so far
      logic                  sat;     // shift magnitude >= SHIFT_SAT
      logic [SH_BITS-1:0]    sh_rem;  // shift amount, consumed level by level
      logic [SIDE_WIDTH-1:0] side;    // sideband, untouched
   } align_pl_t;

   // Two's-complement magnitude; -2^EXPO_WIDTH maps to 2^EXPO_WIDTH.
   function automatic logic [EXPO_WIDTH:0] shift_mag(input logic [EXPO_WIDTH:0] r);
      return r[EXPO_WIDTH] ? (~r + (EXPO_WIDTH+1)'(1)) : r;
   endfunction

endpackage

// File: rtl/mantissa_align_pipe_if.sv
// Upstream/downstream handshake bundle for the mantissa alignment pipe.
interface mantissa_align_pipe_if;
   import fpu_align_pkg::*;

   logic                    in_valid;
   logic                    in_ready;
   logic                    hidden_in;
   logic [MENT_WIDTH-1:0]   smaller_operand_in;
   logic [EXPO_WIDTH:0]     rshift_in;
   logic [SIDE_WIDTH-1:0]   side_in;
   logic                    out_valid;
   logic                    out_ready;
   logic [ALIGN_WIDTH-1:0]  aligned_out;
   logic                    shift_sat_out;
   logic [SIDE_WIDTH-1:0]   side_out;

   // Environment side: drives beats in, consumes aligned results.
   modport master (
      output in_valid, hidden_in, smaller_operand_in, rshift_in, side_in, out_ready,
      input  in_ready, out_valid, aligned_out, shift_sat_out, side_out
   );

   // Pipe side.
   modport slave (
      input  in_valid, hidden_in, smaller_operand_in, rshift_in, side_in, out_ready,
      output in_ready, out_valid, aligned_out, shift_sat_out, side_out
   );

endinterface

// File: rtl/mantissa_align_pipe_shift_stage.sv
// align_shift_stage: applies shift levels LVL_LO..LVL_LO+LVL_N-1 (shift by
// 2^level when that bit of sh_rem is set) and folds dropped bits into sticky.
// Sticky folding exists only when ALIGN_STICKY_EN is defined.
module align_shift_stage
   import fpu_align_pkg::*;
#(
   parameter int LVL_LO = 0,
   parameter int LVL_N  = 1
)(
   input  align_pl_t i_pl,
   output align_pl_t o_pl
);

   align_pl_t w_pl;
`ifdef ALIGN_STICKY_EN
   logic [SHIFT_SAT-1:0] w_mask;
`endif

   // Barrel levels owned by this stage, lowest level first
   always_comb begin
      w_pl = i_pl;
`ifdef ALIGN_STICKY_EN
      w_mask = '0;
`endif
      for (int l = LVL_LO; l < LVL_LO + LVL_N; l++) begin
         if (w_pl.sh_rem[l]) begin
`ifdef ALIGN_STICKY_EN
            w_mask = ~({SHIFT_SAT{1'b1}} << (1 << l));
            w_pl.sticky = w_pl.sticky | (|(w_pl.sig & w_mask));
`endif
            w_pl.sig = w_pl.sig >> (1 << l);
         end
      end
      o_pl = w_pl;
   end

endmodule

// File: rtl/mantissa_align_pipe.sv
// mantissa_align_pipe: elastic, PIPE_STAGES-deep right-shift alignment of the
// smaller significand with guard/round/sticky generation. Global stall: every
// stage advances together whenever the output slot is empty or being taken.
// Optional macro ALIGN_STICKY_EN: when undefined, sticky is forced to 0.
module mantissa_align_pipe
   import fpu_align_pkg::*;
#(
   parameter int PIPE_STAGES = 2
)(
   input  logic                 clk,
   input  logic                 rst,
   mantissa_align_pipe_if.slave bus
);

   localparam int BASE  = SH_BITS / PIPE_STAGES;
   localparam int EXTRA = SH_BITS % PIPE_STAGES;
   localparam logic [EXPO_WIDTH:0] SAT_TH = (EXPO_WIDTH+1)'(SHIFT_SAT);

   logic                   w_en;
   logic [EXPO_WIDTH:0]    w_sh;
   logic                   w_sat;
   logic [SHIFT_SAT-1:0]   w_ext;
   align_pl_t              w_pl0;
   align_pl_t              w_stg_in  [PIPE_STAGES];
   align_pl_t              w_stg_out [PIPE_STAGES];
   align_pl_t              r_pl      [PIPE_STAGES];
   logic [PIPE_STAGES-1:0] r_vld;
   logic [PIPE_STAGES:0]   w_vld_chain;

   assign w_en         = !r_vld[PIPE_STAGES-1] || bus.out_ready;
   assign bus.in_ready = w_en;
   assign w_vld_chain  = {r_vld, bus.in_valid};
   assign w_sh         = shift_mag(bus.rshift_in);
   assign w_sat        = (w_sh >= SAT_TH);
   assign w_ext        = {bus.hidden_in, bus.smaller_operand_in, 2'b00};

   // Saturated shifts skip the barrel: significand empties straight into sticky
   always_comb begin
      w_pl0.sig    = w_sat ? '0 : w_ext;
`ifdef ALIGN_STICKY_EN
      w_pl0.sticky = w_sat & (|w_ext);
`else
      w_pl0.sticky = 1'b0;
`endif
      w_pl0.sat    = w_sat;
      w_pl0.sh_rem = w_sat ? '0 : w_sh[SH_BITS-1:0];
      w_pl0.side   = bus.side_in;
   end

   // Levels split evenly; earlier stages absorb the remainder
   for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
      localparam int LO = s * BASE + ((s < EXTRA) ? s : EXTRA);
      localparam int N  = BASE + ((s < EXTRA) ? 1 : 0);
      if (s == 0) begin : g_head
         assign w_stg_in[s] = w_pl0;
      end else begin : g_body
         assign w_stg_in[s] = r_pl[s-1];
      end
      align_shift_stage #(.LVL_LO(LO), .LVL_N(N)) u_stage (
         .i_pl (w_stg_in[s]),
         .o_pl (w_stg_out[s])
      );
   end

   // Stage registers: all advance together on w_en, bubbles included
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld <= '0;
         for (int s = 0; s < PIPE_STAGES; s++) r_pl[s] <= '0;
      end else if (w_en) begin
         for (int s = 0; s < PIPE_STAGES; s++) begin
            r_vld[s] <= w_vld_chain[s];
            r_pl[s]  <= w_stg_out[s];
         end
      end
   end

   assign bus.out_valid     = r_vld[PIPE_STAGES-1];
   assign bus.aligned_out   = {r_pl[PIPE_STAGES-1].sig, r_pl[PIPE_STAGES-1].sticky};
   assign bus.shift_sat_out = r_pl[PIPE_STAGES-1].sat;
   assign bus.side_out      = r_pl[PIPE_STAGES-1].side;

endmodule

// File: tb/tb_mantissa_align_pipe.sv
// Directed bench for mantissa_align_pipe: driver pushes expected beats into a
// scoreboard queue, an independent monitor pops and compares on every
// transfer. Expected sticky follows ALIGN_STICKY_EN as compiled.
module tb_mantissa_align_pipe;
   import fpu_align_pkg::*;

`ifdef ALIGN_STICKY_EN
   localparam bit STK = 1'b1;
`else
   localparam bit STK = 1'b0;
`endif

   typedef struct {
      logic [ALIGN_WIDTH-1:0] al;
      logic                   sat;
      logic [SIDE_WIDTH-1:0]  side;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   errs   = 0;
   int   checks = 0;
   exp_t sb[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   mantissa_align_pipe_if bus();

   mantissa_align_pipe #(.PIPE_STAGES(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Present one beat, wait for acceptance, record what must come out.
   task automatic send(input logic h, input logic [MENT_WIDTH-1:0] m,
                       input logic [EXPO_WIDTH:0] r, input logic [SIDE_WIDTH-1:0] sd,
                       input logic [ALIGN_WIDTH-1:0] al, input logic sat);
      int   n = 0;
      exp_t e;
      bus.hidden_in          = h;
      bus.smaller_operand_in = m;
      bus.rshift_in          = r;
      bus.side_in            = sd;
      bus.in_valid           = 1'b1;
      @(negedge clk);
      while (!bus.in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!bus.in_ready) begin
         chk("send_timeout", 64'd1, 64'd0);
      end else begin
         e.al = al; e.sat = sat; e.side = sd;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         n++;
         @(posedge clk);
      end
      #1;
      chk("drain_left", 64'(sb.size()), 64'd0);
   endtask

   // Monitor: every transfer must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_beat", 64'd1, 64'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("aligned_out", 64'(bus.aligned_out), 64'(mon_e.al));
            chk("shift_sat",   64'(bus.shift_sat_out), 64'(mon_e.sat));
            chk("side_out",    64'(bus.side_out), 64'(mon_e.side));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst                    = 1'b1;
      bus.in_valid           = 1'b1;   // must be ignored during reset
      bus.hidden_in          = 1'b1;
      bus.smaller_operand_in = '0;
      bus.rshift_in          = '0;
      bus.side_in            = '0;
      bus.out_ready          = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_aligned",   64'(bus.aligned_out), 64'd0);
      chk("rst_sat",       64'(bus.shift_sat_out), 64'd0);
      chk("rst_side",      64'(bus.side_out), 64'd0);
      chk("rst_in_ready",  64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b0;
      rst          = 1'b0;
      @(posedge clk);
      #1;

      // Case 1 plus latency probe: valid only after the second edge
      send(1'b1, 23'h0, 9'd1, 10'h001, 27'h2000000, 1'b0);
      @(negedge clk);
      chk("latency_1cyc_valid", 64'(bus.out_valid), 64'd0);
      @(negedge clk);
      chk("latency_2cyc_valid", 64'(bus.out_valid), 64'd1);
      @(posedge clk);
      #1;

      // Cases 2, 3 and extra patterns, back to back
      send(1'b1, 23'h0,      9'h1FF, 10'h002, 27'h2000000, 1'b0);
      send(1'b1, 23'h0,      9'h000, 10'h003, 27'h4000000, 1'b0);
      send(1'b1, 23'h000001, 9'd25,  10'h004, {26'h1, STK}, 1'b0);
      send(1'b1, 23'h000001, 9'd26,  10'h005, {26'h0, STK}, 1'b1);
      send(1'b1, 23'h000001, 9'h100, 10'h006, {26'h0, STK}, 1'b1);
      send(1'b1, 23'h7FFFFF, 9'd4,   10'h007, {26'h3FFFFF, STK}, 1'b0);
      send(1'b0, 23'h400000, 9'h1FD, 10'h008, 27'h0400000, 1'b0);
      send(1'b1, 23'h123456, 9'h000, 10'h009, 27'h491A2B0, 1'b0);
      send(1'b0, 23'h000000, 9'h0E7, 10'h00A, 27'h0000000, 1'b1);
      drain();

      // Case 4: three beats into a stalled output
      bus.out_ready = 1'b0;
      fork
         begin
            send(1'b1, 23'h0, 9'd1, 10'h011, 27'h2000000, 1'b0);
            send(1'b1, 23'h0, 9'd0, 10'h012, 27'h4000000, 1'b0);
            send(1'b1, 23'h000001, 9'd25, 10'h013, {26'h1, STK}, 1'b0);
         end
         begin
            repeat (3) @(negedge clk);
            chk("stall_in_ready",  64'(bus.in_ready), 64'd0);
            chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
            @(negedge clk);
            chk("stall_hold_aligned", 64'(bus.aligned_out), 64'h2000000);
            chk("stall_hold_side",    64'(bus.side_out), 64'h011);
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
         end
      join
      drain();

      // Case 5: reset with two beats in flight
      send(1'b1, 23'h0, 9'd1, 10'h021, 27'h2000000, 1'b0);
      send(1'b1, 23'h0, 9'd2, 10'h022, 27'h1000000, 1'b0);
      rst = 1'b1;
      sb.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
      chk("flush_aligned",   64'(bus.aligned_out), 64'd0);
      repeat (5) @(posedge clk);
      #1;
      chk("flush_idle_valid", 64'(bus.out_valid), 64'd0);
      send(1'b1, 23'h0, 9'd2, 10'h023, 27'h1000000, 1'b0);
      drain();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
